// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between fetch (I) and load/store (D).
// Optional starvation guard for the fetch side is enabled with `define MEM_ARB_FAIR_EN.

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 i_req,
    input  logic [`WORD_LEN-1:0] i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [`WORD_LEN-1:0] i_rdata,
    output logic                 i_err,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [3:0]           d_wstrb,
    input  logic [`WORD_LEN-1:0] d_addr,
    input  logic [`WORD_LEN-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [`WORD_LEN-1:0] d_rdata,
    output logic                 d_err,

    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [`WORD_LEN-1:0] ram_wdata,
    input  logic [`WORD_LEN-1:0] ram_rdata
);

    localparam int unsigned W = `WORD_LEN;

    logic i_bad;
    logic d_bad;
    logic i_rvalid_q, i_err_q;
    logic d_rvalid_q, d_err_q, d_wr_q;

    // Misaligned, or any bit set above the RAM's word index range.
    assign i_bad = (i_addr[1:0] != 2'b00) | (i_addr[W-1:ADDR_W+2] != '0);
    assign d_bad = (d_addr[1:0] != 2'b00) | (d_addr[W-1:ADDR_W+2] != '0);

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          starve_force;

    assign starve_force = (starve_q == CW'(STARVE_MAX));

    always_comb begin
        i_gnt = rst_n & i_req & (~d_req | starve_force);
        d_gnt = rst_n & d_req & ~i_gnt;
    end

    always_comb begin
        starve_d = starve_q;
        if (i_gnt || !i_req) begin
            starve_d = '0;
        end else if (d_gnt) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        i_gnt = rst_n & i_req & ~d_req;
        d_gnt = rst_n & d_req;
    end
`endif

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = i_addr[ADDR_W+1:2];
        ram_wdata = d_wdata;
        if (d_gnt) begin
            ram_en   = ~d_bad;
            ram_addr = d_addr[ADDR_W+1:2];
            if (d_we && !d_bad) begin
                ram_we = d_wstrb;
            end
        end else if (i_gnt) begin
            ram_en = ~i_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_wr_q     <= 1'b0;
        end else begin
            i_rvalid_q <= i_gnt;
            i_err_q    <= i_gnt & i_bad;
            d_rvalid_q <= d_gnt;
            d_err_q    <= d_gnt & d_bad;
            d_wr_q     <= d_gnt & d_we;
        end
    end

    // Read data is only exposed for good reads; errors and write acks return zero.
    always_comb begin
        i_rvalid = i_rvalid_q;
        i_err    = i_err_q;
        d_rvalid = d_rvalid_q;
        d_err    = d_err_q;
        i_rdata  = (i_rvalid_q && !i_err_q) ? ram_rdata : '0;
        d_rdata  = (d_rvalid_q && !d_err_q && !d_wr_q) ? ram_rdata : '0;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous block RAM (1-cycle read latency, word-addressed) between the instruction-fetch requester (I) and the load/store requester (D).
- Per cycle it grants at most one request, drives the RAM port, and returns the response exactly one cycle after grant.
- Sits between the fetch/LSU stages and the RAM.
- Misaligned or out-of-range byte addresses are rejected with an error response; the RAM is not accessed for them.

Parameters:
- ADDR_W, 12, RAM word-address width (depth 2^ADDR_W words).
- STARVE_MAX, 4, consecutive D grants allowed while I waits (used only with MEM_ARB_FAIR_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  `WORD_LEN  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  `WORD_LEN  fetched word.
- i_err  out  1  fetch response is an error.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_wstrb  in  4  byte write enables (writes only).
- d_addr  in  `WORD_LEN  data byte address.
- d_wdata  in  `WORD_LEN  write data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response valid (read data or write ack).
- d_rdata  out  `WORD_LEN  read word.
- d_err  out  1  data response is an error.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word index.
- ram_wdata  out  `WORD_LEN  RAM write data.
- ram_rdata  in  `WORD_LEN  RAM read data; valid one cycle after ram_en.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - All registered state clears: i_rvalid=0, d_rvalid=0, i_err=0, d_err=0, starve count=0.
  - Combinational outputs follow from the cleared state: grants 0 while rst_n low, ram_en=0, ram_we=0.
- Arbitration (combinational, same cycle):
  - d_req has fixed priority: d_gnt=d_req.
  - i_gnt=i_req & ~d_req.
  - Both gnt signals are never 1 together.
- Address check for the granted request: bad = (addr[1:0]!=0) | (addr[`WORD_LEN-1:ADDR_W+2]!=0).
- RAM drive:
  - ram_en = gnt & ~bad.
  - ram_addr = addr[ADDR_W+1:2].
  - ram_we = d_wstrb when D is granted with d_we=1 and the address is good; otherwise 0.
  - ram_wdata = d_wdata.
- Response registers (set at the grant edge):
  - x_rvalid<=x_gnt.
  - x_err<=bad.
  - A registered is_write flag is kept for D.
- Response data (combinational, cycle after grant):
  - x_rdata = ram_rdata when x_rvalid & ~x_err & ~(D write); otherwise 0.
- Latency and throughput:
  - Exactly one cycle from grant to rvalid.
  - Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.
  - Responses are not back-pressured; requesters must accept rvalid.
- Write followed by read of the same word on the next cycle returns the new data, per the RAM's read-after-write behaviour.
- Simultaneous requests: D wins; I stays pending with i_gnt=0.
- Reset mid-operation: a pending response is dropped, and rvalid is not asserted after reset releases.

Optional Feature:
- MEM_ARB_FAIR_EN defined:
  - A starve counter increments on each cycle with d_gnt & i_req.
  - It clears on i_gnt, or when i_req=0.
  - When count==STARVE_MAX, I is granted over D (D waits one cycle) and the counter clears.
- MEM_ARB_FAIR_EN undefined: pure fixed D priority, no counter logic.

Test Plan:
- Fetch only: i_req=1, i_addr=0x8, mem[2]=0x00500093 -> i_gnt same cycle, ram_addr=2; next cycle i_rvalid=1, i_rdata=0x00500093, i_err=0.
- Data write then read: write d_addr=0x10, d_wstrb=0x3, d_wdata=0xAABBCCDD over 0x11223344, then read 0x10 -> write ack d_rvalid=1 with d_rdata=0; read returns 0x1122CCDD.
- Conflict: i_req=d_req=1 for 3 cycles, with D dropping after 2 grants -> d_gnt cycles 0-1, i_gnt cycle 2; never both high.
- Error cases: i_addr=0x6 -> i_gnt=1, ram_en=0, next cycle i_rvalid=1, i_err=1, i_rdata=0; d_addr=0x4000 with ADDR_W=12 -> d_err=1.
- Reset mid-op: assert rst_n=0 in the cycle after a grant -> i_rvalid and d_rvalid go 0 immediately and stay 0 after release.
- With MEM_ARB_FAIR_EN, STARVE_MAX=4, both requesting continuously -> pattern D,D,D,D,I repeats.
